// File: rtl/nn_ctrl_pkg.sv
// Shared constants for the NN accelerator control path: state encoding and default sizes.
package nn_ctrl_pkg;

  localparam int unsigned NN_MAX_LAYERS = 4;
  localparam int unsigned NN_LEN_W      = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_COMPUTE = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_FINISH  = 3'd4;

endpackage

// File: rtl/nn_phase_counter.sv
// Beat counter for the LOAD/COMPUTE phases; wraps to zero on its own at the last beat.
module nn_phase_counter #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [LEN_W-1:0] i_len,
  output logic [LEN_W-1:0] o_cnt,
  output logic             o_last
);

  logic [LEN_W-1:0] r_cnt;

  // i_len is clamped to >= 1 upstream, so len-1 never underflows.
  assign o_last = (r_cnt == (i_len - LEN_W'(1)));
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_last ? '0 : r_cnt + LEN_W'(1);
    end
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Multi-layer load/compute/write sequencer for the NN accelerator.
// Define NN_SEQ_ABORT_EN to add the abort input and aborted pulse output.
module nn_layer_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int MAX_LAYERS = NN_MAX_LAYERS,
  parameter int LAYER_W    = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1,
  parameter int LEN_W      = NN_LEN_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LAYER_W:0]   num_layers,
  input  logic [LEN_W-1:0]   load_len,
  input  logic [LEN_W-1:0]   compute_len,
  input  logic               write_ack,
  output logic               busy,
  output logic               done,
  output logic               load_mat,
  output logic               computation,
  output logic               write_req,
  output logic [LAYER_W-1:0] layer_idx,
  output logic [LEN_W-1:0]   phase_cnt
`ifdef NN_SEQ_ABORT_EN
  ,
  input  logic               abort,
  output logic               aborted
`endif
);

  localparam logic [LAYER_W:0] MaxLayersV = (LAYER_W + 1)'(MAX_LAYERS);
  localparam logic [LAYER_W:0] OneLayer   = (LAYER_W + 1)'(1);
  localparam logic [LEN_W-1:0] OneBeat    = LEN_W'(1);

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [LAYER_W:0]   r_layers;
  logic [LEN_W-1:0]   r_load_len;
  logic [LEN_W-1:0]   r_comp_len;
  logic [LAYER_W-1:0] r_layer_idx;

  logic [LAYER_W:0]   w_layers_clamped;
  logic [LEN_W-1:0]   w_load_clamped;
  logic [LEN_W-1:0]   w_comp_clamped;
  logic [LEN_W-1:0]   w_phase_len;
  logic [LEN_W-1:0]   w_phase_cnt;
  logic               w_in_phase;
  logic               w_active;
  logic               w_last_beat;
  logic               w_last_layer;
  logic               w_abort;

  always_comb begin
    w_layers_clamped = num_layers;
    if (num_layers == '0) begin
      w_layers_clamped = OneLayer;
    end else if (num_layers > MaxLayersV) begin
      w_layers_clamped = MaxLayersV;
    end
  end

  assign w_load_clamped = (load_len == '0) ? OneBeat : load_len;
  assign w_comp_clamped = (compute_len == '0) ? OneBeat : compute_len;

  assign w_in_phase   = (r_state == ST_LOAD) || (r_state == ST_COMPUTE);
  assign w_active     = w_in_phase || (r_state == ST_WRITE);
  assign w_phase_len  = (r_state == ST_LOAD) ? r_load_len : r_comp_len;
  assign w_last_layer = ({1'b0, r_layer_idx} == (r_layers - OneLayer));

`ifdef NN_SEQ_ABORT_EN
  logic r_aborted;

  assign w_abort = abort && w_active;
  assign aborted = r_aborted;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= w_abort;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  nn_phase_counter #(
    .LEN_W (LEN_W)
  ) u_phase_counter (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_abort),
    .i_en    (w_in_phase),
    .i_len   (w_phase_len),
    .o_cnt   (w_phase_cnt),
    .o_last  (w_last_beat)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_next = ST_LOAD;
      ST_LOAD:    if (w_last_beat) w_state_next = ST_COMPUTE;
      ST_COMPUTE: if (w_last_beat) w_state_next = ST_WRITE;
      ST_WRITE:   if (write_ack) w_state_next = w_last_layer ? ST_FINISH : ST_LOAD;
      ST_FINISH:  w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
    // Abort overrides any phase completion or write handshake in the same cycle.
    if (w_abort) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_layers    <= OneLayer;
      r_load_len  <= OneBeat;
      r_comp_len  <= OneBeat;
      r_layer_idx <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_abort) begin
        r_layer_idx <= '0;
      end else if ((r_state == ST_IDLE) && start) begin
        r_layers    <= w_layers_clamped;
        r_load_len  <= w_load_clamped;
        r_comp_len  <= w_comp_clamped;
        r_layer_idx <= '0;
      end else if ((r_state == ST_WRITE) && write_ack && !w_last_layer) begin
        r_layer_idx <= r_layer_idx + LAYER_W'(1);
      end
    end
  end

  assign busy        = w_active;
  assign done        = (r_state == ST_FINISH);
  assign load_mat    = (r_state == ST_LOAD);
  assign computation = (r_state == ST_COMPUTE);
  assign write_req   = (r_state == ST_WRITE);
  assign layer_idx   = r_layer_idx;
  assign phase_cnt   = w_phase_cnt;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer; abort scenario is built only with NN_SEQ_ABORT_EN.
module tb_nn_layer_sequencer;
  import nn_ctrl_pkg::*;

  localparam int MaxL   = NN_MAX_LAYERS;
  localparam int LayerW = (MaxL > 1) ? $clog2(MaxL) : 1;
  localparam int LenW   = NN_LEN_W;

  typedef struct {
    int layers;
    int lat;
  } exp_t;

  logic              clk         = 1'b0;
  logic              reset       = 1'b1;
  logic              start       = 1'b0;
  logic [LayerW:0]   num_layers  = '0;
  logic [LenW-1:0]   load_len    = '0;
  logic [LenW-1:0]   compute_len = '0;
  logic              write_ack   = 1'b0;
  logic              busy;
  logic              done;
  logic              load_mat;
  logic              computation;
  logic              write_req;
  logic [LayerW-1:0] layer_idx;
  logic [LenW-1:0]   phase_cnt;
`ifdef NN_SEQ_ABORT_EN
  logic              abort = 1'b0;
  logic              aborted;
`endif

  nn_layer_sequencer #(
    .MAX_LAYERS (MaxL),
    .LAYER_W    (LayerW),
    .LEN_W      (LenW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_layers  (num_layers),
    .load_len    (load_len),
    .compute_len (compute_len),
    .write_ack   (write_ack),
    .busy        (busy),
    .done        (done),
    .load_mat    (load_mat),
    .computation (computation),
    .write_req   (write_req),
    .layer_idx   (layer_idx),
    .phase_cnt   (phase_cnt)
`ifdef NN_SEQ_ABORT_EN
    ,
    .abort       (abort),
    .aborted     (aborted)
`endif
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done = 0;
  int   ld_run = 0, c_run = 0, wr_run = 0, writes = 0;
  int   exp_l = 1, exp_c = 1, ack_delay = 0, t_start = 0;
  bit   ack_tie = 1'b0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int want);
    n_checks++;
    if (obs != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  // Monitor and write-ack responder, both on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      write_ack = ack_tie;
    end else begin
      check("onehot", int'($countones({load_mat, computation, write_req, done}) <= 1), 1);
      check("busy", busy, load_mat | computation | write_req);
      if (load_mat) begin
        check("ld_beat", phase_cnt, ld_run);
        ld_run++;
      end else if (ld_run != 0) begin
        check("ld_len", ld_run, exp_l);
        ld_run = 0;
      end
      if (computation) begin
        check("c_beat", phase_cnt, c_run);
        c_run++;
      end else if (c_run != 0) begin
        check("c_len", c_run, exp_c);
        c_run = 0;
      end
      if (!load_mat && !computation) check("pc_zero", phase_cnt, 0);
      write_ack = ack_tie || (write_req && (wr_run >= ack_delay));
      if (write_req) begin
        if (wr_run == 0) check("layer_idx", layer_idx, writes);
        if (write_ack) begin
          writes++;
          wr_run = 0;
        end else begin
          wr_run++;
        end
      end
      if (done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("done_spurious", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("latency", cyc - t_start, e.lat);
          check("layers", writes, e.layers);
          check("final_idx", layer_idx, e.layers - 1);
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 of the first run cycle.
  task automatic kick(input int n, input int l, input int c, input int dly, input bit tie);
    exp_t e;
    int   en;
    en = (n == 0) ? 1 : ((n > MaxL) ? MaxL : n);
    exp_l     = (l == 0) ? 1 : l;
    exp_c     = (c == 0) ? 1 : c;
    ack_delay = tie ? 0 : dly;
    ack_tie   = tie;
    ld_run = 0; c_run = 0; wr_run = 0; writes = 0;
    e.layers = en;
    e.lat    = en * (exp_l + exp_c + ack_delay + 1) + 1;
    exp_q.push_back(e);
    num_layers  = (LayerW + 1)'(n);
    load_len    = LenW'(l);
    compute_len = LenW'(c);
    start   = 1'b1;
    t_start = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit);
    int k;
    k = 0;
    while (n_done == base && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    if (n_done == base) check("done_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_load"}, load_mat, 0);
    check({tag, "_comp"}, computation, 0);
    check({tag, "_wreq"}, write_req, 0);
    check({tag, "_idx"}, layer_idx, 0);
    check({tag, "_pcnt"}, phase_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish (checks %0d errors %0d)",
             n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    int base;
    int k;
    repeat (3) @(posedge clk);
    #1;
    idle_checks("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // Single layer, single beats, ack tied high.
    base = n_done;
    kick(1, 1, 1, 0, 1'b1);
    check("t1_load", load_mat, 1);
    check("t1_busy1", busy, 1);
    @(posedge clk); #1;
    check("t1_comp", computation, 1);
    @(posedge clk); #1;
    check("t1_wreq", write_req, 1);
    @(posedge clk); #1;
    check("t1_done", done, 1);
    check("t1_busy4", busy, 0);
    @(posedge clk); #1;
    check("t1_done_off", done, 0);
    wait_done(base, 10);

    // Three layers with a two-cycle write; done at t+25.
    base = n_done;
    kick(3, 4, 2, 1, 1'b0);
    wait_done(base, 200);

    // Clamping.
    base = n_done;
    kick(0, 0, 3, 0, 1'b0);
    wait_done(base, 200);
    base = n_done;
    kick(7, 2, 1, 0, 1'b0);
    wait_done(base, 200);

    // start and config changes mid-run, plus start during FINISH.
    base = n_done;
    kick(2, 3, 3, 0, 1'b0);
    k = 0;
    while (!computation && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("t5_in_comp", computation, 1);
    start = 1'b1; num_layers = 4; load_len = 9; compute_len = 9;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!done && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("t5_in_finish", done, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t5_idle", busy, 0);
    check("t5_one_done", n_done - base, 1);

    // Reset during WRITE of layer 1.
    base = n_done;
    kick(3, 2, 2, 1, 1'b0);
    k = 0;
    while (!(write_req && layer_idx == 1) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("t6_in_wr1", int'(write_req && layer_idx == 1), 1);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    idle_checks("t6");
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_done", n_done - base, 0);
    base = n_done;
    kick(2, 1, 2, 2, 1'b0);
    wait_done(base, 200);

    for (int i = 0; i < 4; i++) begin
      base = n_done;
      kick(int'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
           int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), 1'b0);
      wait_done(base, 500);
    end

`ifdef NN_SEQ_ABORT_EN
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("ab_idle_ignored", aborted, 0);
    base = n_done;
    kick(3, 2, 3, 0, 1'b0);
    k = 0;
    while (!(computation && layer_idx == 2 && phase_cnt == 2) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("ab_at_last_beat", int'(computation && layer_idx == 2 && phase_cnt == 2), 1);
    abort = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    abort = 1'b0;
    check("ab_pulse", aborted, 1);
    check("ab_busy", busy, 0);
    check("ab_wreq", write_req, 0);
    check("ab_idx", layer_idx, 0);
    @(posedge clk); #1;
    check("ab_pulse_off", aborted, 0);
    repeat (10) @(posedge clk);
    #1;
    check("ab_no_done", n_done - base, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
